uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial transmitter that pairs with the team's UART receiver. It accepts a byte over a valid/ready handshake and serialises it on a single line. The frame is a start bit, 8 data bits sent MSB first (D7 first), an optional parity bit, and 1 or 2 stop bits. Frame format and baud rate come from the same 8-bit operating-mode byte the receiver uses, so both ends of a link are configured from one value.

Parameters:
DIV0, 10416, clocks per bit when MODE[7:6]=00
DIV1, 5208, clocks per bit when MODE[7:6]=01
DIV2, 2604, clocks per bit when MODE[7:6]=10
DIV3, 868, clocks per bit when MODE[7:6]=11 (all DIVn are 16-bit, legal range 2..65535)

Ports:
Clock  in  1  system clock; the only clock, all logic on its rising edge
Reset  in  1  synchronous, active-high reset
MODE  in  8  operating mode, sampled at frame accept: [7:6] baud select, [5] 0=two stop bits/1=one stop bit, [1] 0=even/1=odd parity, [0] parity enable
DATA_IN  in  8  byte to transmit
TX_VALID  in  1  DATA_IN holds a valid byte
TX_READY  out  1  transmitter can accept a byte this cycle
CTS  in  1  clear-to-send from the far end; a new frame starts only while high
TXD  out  1  serial line, idles high
BUSY  out  1  frame in progress
TX_DONE  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values: TXD=1, BUSY=0, TX_DONE=0, state IDLE, bit counter 0. TX_READY follows IDLE && CTS.
- Reset mid-frame: the frame is abandoned. TXD=1 on the following cycle with no truncated glitch beyond that edge.
- Reset has priority over every other input.
- TX_READY is combinational: state==IDLE && CTS && !Reset.
- Accept: occurs on a rising edge where TX_VALID && TX_READY. At that edge DATA_IN and MODE are latched into shadow registers, and BUSY rises.
- Changes to MODE or DATA_IN during a frame have no effect on that frame.
- States: IDLE -> START -> DATA (8 bits, index 7 down to 0) -> PARITY (only if latched MODE[0]=1) -> STOP1 -> STOP2 (only if latched MODE[5]=0) -> IDLE.
- Bit timing: every state except IDLE drives TXD for exactly DIV clocks, where DIV is selected by latched MODE[7:6].
- The 16-bit counter runs 0..DIV-1. The state advances on the edge where counter==DIV-1, and the counter wraps to 0 on that edge.
- Latency: TXD goes low (start bit) on the cycle after the accept edge.
- Frame length: (1+8+P+S)*DIV clocks, where P = MODE[0] and S = 2-MODE[5].
- Line values: START drives 0; DATA drives shadow[7-i]; STOP drives 1.
- Parity: PARITY drives XOR of the 8 data bits when MODE[1]=0 (even: total ones in data plus parity is even). It drives the inverse when MODE[1]=1 (odd).
- Completion: on the edge ending the last stop bit, state=IDLE, BUSY=0, and TX_DONE=1 for exactly one cycle. TXD stays 1.
- Back-to-back: a new accept is allowed in the TX_DONE cycle. The new start bit then begins one cycle later, so the minimum gap is 1 idle-high cycle after the stop bit(s).
- CTS: sampled only for accept. CTS falling mid-frame does not stop or stretch the frame. With CTS low in IDLE, TX_READY=0 and TX_VALID is held off indefinitely.
- TX_VALID while BUSY is ignored and no data is lost internally. The source must hold the byte until TX_READY.

Test Plan:
- Bench parameters: DIV0=8, DIV1=6, DIV2=4, DIV3=3.
- Reset then idle: TXD=1, BUSY=0, TX_DONE=0; with CTS=1, TX_READY=1.
- MODE=8'hC1 (DIV3, even parity, two stop bits), DATA_IN=8'hA5, one-cycle TX_VALID.
  - TXD from the next cycle, each bit 3 clocks: 0,1,0,1,0,0,1,0,1,0(parity),1,1 = 36 clocks.
  - TX_DONE pulses once on the cycle after clock 36.
- MODE=8'hC3 (odd parity), DATA_IN=8'hA5: identical frame except the parity bit is 1.
- MODE=8'hE0 (DIV3, no parity, one stop bit), DATA_IN=8'h00 -> TXD low for 27 clocks, high 3 clocks, 30-clock frame.
- MODE=8'h20 (DIV0), DATA_IN=8'hFF -> 80-clock frame; start bit exactly 8 clocks low.
  - Change MODE to 8'hC1 mid-frame -> the frame still completes with the 8'h20 format.
- Flow control and reset:
  - CTS=0 with TX_VALID=1 for 20 cycles -> no accept, TXD=1.
  - Raise CTS -> accept on the same edge.
  - Drop CTS mid-frame -> the frame completes.
  - Assert Reset at clock 10 of a frame -> TXD=1 and BUSY=0 next cycle, no TX_DONE.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte-wide UART transmitter, MSB first, mode-byte framing
module uart_tx #(
   parameter logic [15:0] DIV0 = 16'd10416,
   parameter logic [15:0] DIV1 = 16'd5208,
   parameter logic [15:0] DIV2 = 16'd2604,
   parameter logic [15:0] DIV3 = 16'd868
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] MODE,
   input  logic [7:0] DATA_IN,
   input  logic       TX_VALID,
   output logic       TX_READY,
   input  logic       CTS,
   output logic       TXD,
   output logic       BUSY,
   output logic       TX_DONE
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shadow;
   logic [1:0]  baud_q;
   logic        one_stop_q;
   logic        odd_q;
   logic        par_en_q;
   logic [15:0] div;
   logic        bit_end;

   // Bit period for the format latched at accept, so mid-frame MODE changes are ignored
   always_comb begin
      div = DIV0;
      case (baud_q)
         2'b00:   div = DIV0;
         2'b01:   div = DIV1;
         2'b10:   div = DIV2;
         default: div = DIV3;
      endcase
   end

   assign bit_end  = (cnt == div - 16'd1);
   assign TX_READY = (state == IDLE) && CTS && !Reset;

   // Frame sequencer; TXD is registered and loaded with the next bit's value on each bit boundary
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= 16'd0;
         bit_idx    <= 3'd0;
         shadow     <= 8'd0;
         baud_q     <= 2'b00;
         one_stop_q <= 1'b0;
         odd_q      <= 1'b0;
         par_en_q   <= 1'b0;
         TXD        <= 1'b1;
         BUSY       <= 1'b0;
         TX_DONE    <= 1'b0;
      end else begin
         TX_DONE <= 1'b0;
         if (state == IDLE) begin
            TXD <= 1'b1;
            cnt <= 16'd0;
            if (TX_VALID && CTS) begin
               shadow     <= DATA_IN;
               baud_q     <= MODE[7:6];
               one_stop_q <= MODE[5];
               odd_q      <= MODE[1];
               par_en_q   <= MODE[0];
               BUSY       <= 1'b1;
               TXD        <= 1'b0;
               state      <= START;
            end
         end else if (!bit_end) begin
            cnt <= cnt + 16'd1;
         end else begin
            cnt <= 16'd0;
            case (state)
               START: begin
                  state   <= DATA;
                  bit_idx <= 3'd7;
                  TXD     <= shadow[7];
               end
               DATA: begin
                  if (bit_idx != 3'd0) begin
                     bit_idx <= bit_idx - 3'd1;
                     TXD     <= shadow[bit_idx - 3'd1];
                  end else if (par_en_q) begin
                     state <= PARITY;
                     TXD   <= (^shadow) ^ odd_q;
                  end else begin
                     state <= STOP1;
                     TXD   <= 1'b1;
                  end
               end
               PARITY: begin
                  state <= STOP1;
                  TXD   <= 1'b1;
               end
               STOP1: begin
                  TXD <= 1'b1;
                  if (!one_stop_q) begin
                     state <= STOP2;
                  end else begin
                     state   <= IDLE;
                     BUSY    <= 1'b0;
                     TX_DONE <= 1'b1;
                  end
               end
               default: begin
                  TXD     <= 1'b1;
                  state   <= IDLE;
                  BUSY    <= 1'b0;
                  TX_DONE <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a frame-level reference model
module tb_uart_tx;

   logic       Clock = 1'b0;
   logic       Reset;
   logic [7:0] MODE;
   logic [7:0] DATA_IN;
   logic       TX_VALID;
   logic       TX_READY;
   logic       CTS;
   logic       TXD;
   logic       BUSY;
   logic       TX_DONE;

   int total = 0;
   int bad   = 0;
   int divtab [4] = '{8, 6, 4, 3};

   bit exp_q [$];
   int done_q [$];
   int busy_cnt = 0;

   uart_tx #(.DIV0(16'd8), .DIV1(16'd6), .DIV2(16'd4), .DIV3(16'd3)) dut (
      .Clock(Clock), .Reset(Reset), .MODE(MODE), .DATA_IN(DATA_IN),
      .TX_VALID(TX_VALID), .TX_READY(TX_READY), .CTS(CTS),
      .TXD(TXD), .BUSY(BUSY), .TX_DONE(TX_DONE)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected line waveform: one entry per clock while the frame is in progress
   task automatic push_frame(input logic [7:0] m, input logic [7:0] d);
      bit bits [$];
      int div = divtab[m[7:6]];
      bits.push_back(1'b0);
      for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
      if (m[0]) bits.push_back((^d) ^ m[1]);
      bits.push_back(1'b1);
      if (!m[5]) bits.push_back(1'b1);
      foreach (bits[k]) repeat (div) exp_q.push_back(bits[k]);
      done_q.push_back(bits.size() * div);
   endtask

   // Caller is at posedge+1; returns at posedge+1 of the accept edge
   task automatic send(input logic [7:0] m, input logic [7:0] d, output bit done_at_acc);
      bit ok = 0;
      int w = 0;
      done_at_acc = 0;
      MODE = m; DATA_IN = d; TX_VALID = 1'b1;
      while (!ok && w < 400) begin
         @(negedge Clock);
         if (TX_READY) begin
            ok = 1;
            done_at_acc = TX_DONE;
         end
         @(posedge Clock); #1;
         w++;
      end
      TX_VALID = 1'b0;
      if (ok) push_frame(m, d);
      else chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int w = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0 || BUSY) && w < 2000) begin
         @(posedge Clock);
         w++;
      end
      #1;
      if (w >= 2000) chk("idle_timeout", 0, 1);
   endtask

   // Monitor: compares the line against the expected waveform and frame lengths at TX_DONE
   initial begin
      forever begin
         @(negedge Clock);
         if (Reset) begin
            busy_cnt = 0;
         end else begin
            if (BUSY) begin
               if (exp_q.size() == 0) chk("unexpected_busy", 1, 0);
               else chk("txd_bit", TXD, exp_q.pop_front());
               busy_cnt++;
            end else begin
               chk("txd_idle", TXD, 1);
            end
            if (TX_DONE) begin
               if (done_q.size() == 0) chk("unexpected_done", 1, 0);
               else chk("frame_len", busy_cnt, done_q.pop_front());
               chk("frame_consumed", exp_q.size(), 0);
               busy_cnt = 0;
            end
         end
      end
   end

   initial begin
      bit da;
      logic [7:0] m, d;
      Reset = 1'b1; MODE = 8'h00; DATA_IN = 8'h00; TX_VALID = 1'b0; CTS = 1'b1;
      @(negedge Clock);
      chk("ready_in_reset", TX_READY, 0);
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      chk("reset_state", {TXD, BUSY, TX_DONE, TX_READY}, 4'b1001);
      @(posedge Clock); #1;

      // Directed formats
      send(8'hC1, 8'hA5, da); wait_idle();
      send(8'hC3, 8'hA5, da); wait_idle();
      send(8'hE0, 8'h00, da); wait_idle();
      send(8'h20, 8'hFF, da);
      MODE = 8'hC1; DATA_IN = 8'h12;
      wait_idle();

      // Back-to-back: second accept lands in the TX_DONE cycle
      send(8'hE1, 8'h5A, da);
      send(8'hC0, 8'h81, da);
      chk("b2b_accept_in_done", da, 1);
      wait_idle();

      // CTS hold-off then accept on the rising-CTS edge, CTS dropped mid-frame
      CTS = 1'b0; MODE = 8'hE0; DATA_IN = 8'h3C; TX_VALID = 1'b1;
      repeat (20) begin
         @(negedge Clock);
         chk("cts_hold", {TX_READY, BUSY, TXD}, 3'b001);
      end
      @(posedge Clock); #1 CTS = 1'b1;
      @(negedge Clock);
      chk("cts_ready", TX_READY, 1);
      @(posedge Clock); #1;
      push_frame(8'hE0, 8'h3C);
      TX_VALID = 1'b0;
      chk("cts_accept", {BUSY, TXD}, 2'b10);
      repeat (5) @(posedge Clock);
      #1 CTS = 1'b0;
      wait_idle();
      CTS = 1'b1;

      // Randomized frames with random gaps and CTS glitches
      for (int i = 0; i < 25; i++) begin
         m = 8'($urandom);
         d = 8'($urandom);
         send(m, d, da);
         CTS = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 30)) @(posedge Clock);
         #1 CTS = 1'b1;
         if ($urandom_range(0, 2) == 0) wait_idle();
      end
      wait_idle();

      // Reset at clock 10 of a frame
      send(8'h20, 8'hFF, da);
      repeat (9) @(posedge Clock);
      #1 Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      exp_q.delete();
      done_q.delete();
      chk("reset_mid_frame", {TXD, BUSY, TX_DONE}, 3'b100);
      repeat (20) begin
         @(negedge Clock);
         chk("no_done_after_reset", TX_DONE, 0);
      end
      chk("ready_after_reset", TX_READY, 1);
      @(posedge Clock); #1;
      send(8'hA3, 8'h96, da);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
